// File: rtl/uart_tx_gen2_if.sv
// Host-side valid/ready character channel feeding the uart_tx_gen2 transmitter.
interface uart_tx_gen2_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] p_data_in;

  modport master (output valid, output p_data_in, input ready);
  modport slave  (input valid, input p_data_in, output ready);
endinterface

// File: rtl/uart_tx_gen2.sv
// UART transmitter: buffer FIFO or one-entry direct register feeding a frame engine
// with runtime character length, parity, stop length and break generation.
module uart_tx_gen2 #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned SAMPLING   = 16,
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bclk,
  input  logic             mode,
  input  logic [3:0]       char_len,
  input  logic [1:0]       parity_select,
  input  logic [1:0]       stop_select,
  input  logic             break_req,
  input  logic             flush,
  uart_tx_gen2_if.slave    bus,
  output logic             s_data_out,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned TICK_W = $clog2(2 * SAMPLING) + 1;
  localparam logic [TICK_W-1:0] T_ONE  = TICK_W'(SAMPLING);
  localparam logic [TICK_W-1:0] T_TWO  = TICK_W'(2 * SAMPLING);
  localparam logic [TICK_W-1:0] T_HALF = TICK_W'((3 * SAMPLING) / 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_pend_vld;
  logic [DATA_WIDTH-1:0] r_pend_data;
  logic                  r_run, r_ovf;
  logic [TICK_W-1:0]     r_tick, r_stop_len;
  logic [3:0]            r_len, r_bit_cnt;
  logic [1:0]            r_par_sel;
  logic                  r_par_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx, r_busy;

  logic                  w_fifo_empty, w_full, w_ready, w_push, w_dpush, w_avail;
  logic                  w_bit_end, w_stop_end, w_launch, w_pop, w_take_pend;
  logic [3:0]            w_len;
  logic [DATA_WIDTH-1:0] w_char;
  logic                  w_par_x, w_par_bit;
  logic [TICK_W-1:0]     w_stop_len;

  assign w_fifo_empty = (r_level == '0);
  assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_ready      = r_run & (mode ? ((r_state == S_IDLE) & ~r_pend_vld & w_fifo_empty)
                                      : ~w_full);
  assign w_push       = bus.valid & w_ready & ~mode & ~flush;
  assign w_dpush      = bus.valid & w_ready & mode;
  assign w_avail      = ~w_fifo_empty | r_pend_vld;
  assign w_bit_end    = (r_tick == T_ONE - TICK_W'(1));
  assign w_stop_end   = (r_tick == r_stop_len - TICK_W'(1));
  assign w_launch     = bclk & w_avail & ~break_req &
                        ((r_state == S_IDLE) | ((r_state == S_STOP) & w_stop_end));
  // FIFO content is older than anything in the pending register, so it drains first.
  assign w_pop        = w_launch & ~w_fifo_empty;
  assign w_take_pend  = w_launch & w_fifo_empty;
  assign w_char       = w_fifo_empty ? r_pend_data : r_mem[r_rd_ptr];

  assign w_len = (char_len < 4'd5)                 ? 4'd5 :
                 (char_len > 4'(DATA_WIDTH))       ? 4'(DATA_WIDTH) : char_len;

  always_comb begin
    w_par_x = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (4'(i) < w_len) w_par_x = w_par_x ^ w_char[i];
    end
  end

  always_comb begin
    w_par_bit  = 1'b1;
    w_stop_len = T_TWO;
    case (parity_select)
      2'b01:   w_par_bit = ~w_par_x;
      2'b10:   w_par_bit = w_par_x;
      default: w_par_bit = 1'b1;
    endcase
    case (stop_select)
      2'b00:   w_stop_len = T_ONE;
      2'b10:   w_stop_len = T_HALF;
      default: w_stop_len = T_TWO;
    endcase
  end

  assign bus.ready  = w_ready;
  assign s_data_out = r_tx;
  assign busy       = r_busy;
  assign fifo_level = r_level;
  assign overflow   = r_ovf;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.p_data_in;
  end

  // Buffer bookkeeping: pointers, level, pending register, overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
      r_run       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push & ~w_pop)      r_level <= r_level + LVL_W'(1);
        else if (~w_push & w_pop) r_level <= r_level - LVL_W'(1);
        if (r_run & bus.valid & ~w_ready & ~mode) r_ovf <= 1'b1;
      end
      if (w_dpush) begin
        r_pend_vld  <= 1'b1;
        r_pend_data <= bus.p_data_in;
      end else if (w_take_pend) begin
        r_pend_vld  <= 1'b0;
      end
    end
  end

  // Frame engine; a launch at the end of the case overrides the IDLE/STOP exits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_stop_len <= T_ONE;
      r_len      <= 4'd8;
      r_bit_cnt  <= '0;
      r_par_sel  <= '0;
      r_par_bit  <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else if (bclk) begin
      unique case (r_state)
        S_IDLE: begin
          if (break_req) begin
            r_state <= S_BREAK;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tick    <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_tick <= '0;
            if (r_bit_cnt == r_len - 4'd1) begin
              if (r_par_sel != 2'b00) begin
                r_state <= S_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tick  <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_STOP: begin
          if (w_stop_end) begin
            r_tick <= '0;
            if (break_req) begin
              r_state <= S_BREAK;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        S_BREAK: begin
          // Mark-after-break is always one full bit period.
          if (!break_req) begin
            r_state    <= S_STOP;
            r_tick     <= '0;
            r_stop_len <= T_ONE;
            r_tx       <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_launch) begin
        r_state    <= S_START;
        r_tick     <= '0;
        r_bit_cnt  <= '0;
        r_shift    <= w_char;
        r_len      <= w_len;
        r_par_sel  <= parity_select;
        r_par_bit  <= w_par_bit;
        r_stop_len <= w_stop_len;
        r_tx       <= 1'b0;
        r_busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Directed self-checking bench for uart_tx_gen2 (8-bit, 16x sampling, 16-deep FIFO).
module tb_uart_tx_gen2;

  logic       clk;
  logic       reset;
  logic       bclk;
  logic       mode;
  logic [3:0] char_len;
  logic [1:0] parity_select;
  logic [1:0] stop_select;
  logic       break_req;
  logic       flush;
  logic       s_data_out;
  logic       busy;
  logic [4:0] fifo_level;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_gen2_if #(.DATA_WIDTH(8)) u_if ();

  uart_tx_gen2 #(.DATA_WIDTH(8), .SAMPLING(16), .FIFO_DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .bclk          (bclk),
    .mode          (mode),
    .char_len      (char_len),
    .parity_select (parity_select),
    .stop_select   (stop_select),
    .break_req     (break_req),
    .flush         (flush),
    .bus           (u_if),
    .s_data_out    (s_data_out),
    .busy          (busy),
    .fifo_level    (fifo_level),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push one character and land just after the edge that starts its frame (bclk=1, idle).
  task automatic push_and_launch(input string tag, input logic [7:0] data);
    u_if.valid     = 1'b1;
    u_if.p_data_in = data;
    step(1);
    u_if.valid = 1'b0;
    check({tag, "_idle_before"}, s_data_out, 1);
    step(1);
    check({tag, "_launch"}, s_data_out, 0);
    check({tag, "_busy"}, busy, 1);
  endtask

  // Called just after the launch edge; bits[i] is the i-th bit after the start bit.
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nb,
                             input int stop_ticks, input bit last);
    int cur;
    int total;
    cur   = 0;
    total = 16 * (nb + 1);
    step(8);
    cur = 8;
    check({tag, "_start"}, s_data_out, 0);
    for (int i = 0; i < nb; i++) begin
      step(16 * (i + 1) + 8 - cur);
      cur = 16 * (i + 1) + 8;
      check($sformatf("%s_bit%0d", tag, i), s_data_out, bits[i]);
    end
    step(total - cur);
    check({tag, "_stop_first"}, s_data_out, 1);
    step(stop_ticks - 1);
    check({tag, "_stop_last"}, s_data_out, 1);
    check({tag, "_stop_busy"}, busy, 1);
    step(1);
    if (last) begin
      check({tag, "_end_busy"}, busy, 0);
      check({tag, "_end_line"}, s_data_out, 1);
    end else begin
      check({tag, "_next_low"}, s_data_out, 0);
      check({tag, "_next_busy"}, busy, 1);
    end
  endtask

  initial begin
    reset          = 1'b0;
    bclk           = 1'b0;
    mode           = 1'b0;
    char_len       = 4'd8;
    parity_select  = 2'b00;
    stop_select    = 2'b00;
    break_req      = 1'b0;
    flush          = 1'b0;
    u_if.valid     = 1'b0;
    u_if.p_data_in = 8'h00;

    #23;
    check("rst_line", s_data_out, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", u_if.ready, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    step(1);
    reset = 1'b1;
    step(1);
    check("post_rst_ready", u_if.ready, 1);

    // 8N1 0xA5, bclk every cycle
    bclk = 1'b1;
    u_if.valid     = 1'b1;
    u_if.p_data_in = 8'hA5;
    step(1);
    u_if.valid = 1'b0;
    check("t1_level1", fifo_level, 1);
    check("t1_idle", s_data_out, 1);
    step(1);
    check("t1_launch", s_data_out, 0);
    check("t1_level0", fifo_level, 0);
    check_frame("t1", 16'h00A5, 8, 16, 1'b1);

    // 7E2 0xD3: bit 7 ignored, even parity over 1,1,0,0,1,0,1 is 0
    char_len = 4'd7; parity_select = 2'b10; stop_select = 2'b01;
    push_and_launch("t2", 8'hD3);
    check_frame("t2", 16'h0053, 8, 32, 1'b1);

    // char_len 12 clamps to 8, odd parity of 0x0F is 1, two stops; config changed mid-frame
    char_len = 4'd12; parity_select = 2'b01; stop_select = 2'b11;
    push_and_launch("t2b", 8'h0F);
    char_len = 4'd5; parity_select = 2'b00; stop_select = 2'b00;
    check_frame("t2b", 16'h010F, 9, 32, 1'b1);

    // char_len 3 clamps to 5, mark parity, 1.5 stops
    char_len = 4'd3; parity_select = 2'b11; stop_select = 2'b10;
    push_and_launch("t2c", 8'hF5);
    check_frame("t2c", 16'h0035, 6, 24, 1'b1);
    char_len = 4'd8; parity_select = 2'b00; stop_select = 2'b00;

    // Fill with line stalled, overflow, flush
    bclk = 1'b0;
    u_if.valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      u_if.p_data_in = 8'(i + 8'h10);
      step(1);
      if (i == 15) begin
        check("t3_full_level", fifo_level, 16);
        check("t3_full_ready", u_if.ready, 0);
        check("t3_no_ovf_yet", overflow, 0);
      end
    end
    u_if.valid = 1'b0;
    check("t3_ovf", overflow, 1);
    check("t3_level_after_drop", fifo_level, 16);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("t3_flush_level", fifo_level, 0);
    check("t3_flush_ovf", overflow, 0);
    check("t3_flush_ready", u_if.ready, 1);
    u_if.valid = 1'b1;
    flush      = 1'b1;
    step(1);
    u_if.valid = 1'b0;
    flush      = 1'b0;
    check("t3_write_with_flush", fifo_level, 0);

    // Three queued frames back-to-back
    u_if.valid = 1'b1;
    u_if.p_data_in = 8'h01; step(1);
    u_if.p_data_in = 8'hFF; step(1);
    u_if.p_data_in = 8'h80; step(1);
    u_if.valid = 1'b0;
    check("t4_level3", fifo_level, 3);
    bclk = 1'b1;
    step(1);
    check("t4_launch", s_data_out, 0);
    check("t4_level2", fifo_level, 2);
    check_frame("t4a", 16'h0001, 8, 16, 1'b0);
    check("t4_level1", fifo_level, 1);
    check_frame("t4b", 16'h00FF, 8, 16, 1'b0);
    check("t4_level0", fifo_level, 0);
    check_frame("t4c", 16'h0080, 8, 16, 1'b1);

    // Direct mode: second valid held during the frame must wait
    mode = 1'b1;
    bclk = 1'b0;
    step(1);
    check("t5_ready_idle", u_if.ready, 1);
    u_if.valid     = 1'b1;
    u_if.p_data_in = 8'h3C;
    step(1);
    check("t5_ready_drop", u_if.ready, 0);
    u_if.p_data_in = 8'h77;
    step(1);
    check("t5_ready_pending", u_if.ready, 0);
    check("t5_no_bclk_no_start", s_data_out, 1);
    bclk = 1'b1;
    step(1);
    check("t5_launch", s_data_out, 0);
    check("t5_ready_busy", u_if.ready, 0);
    check_frame("t5a", 16'h003C, 8, 16, 1'b1);
    check("t5_ready_end", u_if.ready, 1);
    step(1);
    u_if.valid = 1'b0;
    check("t5_ready_taken", u_if.ready, 0);
    step(1);
    check("t5b_launch", s_data_out, 0);
    check_frame("t5b", 16'h0077, 8, 16, 1'b1);
    check("t5_ready_final", u_if.ready, 1);
    mode = 1'b0;

    // Break requested mid-frame, mark-after-break, then reset mid-frame
    bclk = 1'b0;
    u_if.valid = 1'b1;
    u_if.p_data_in = 8'h55; step(1);
    u_if.p_data_in = 8'hAA; step(1);
    u_if.valid = 1'b0;
    bclk = 1'b1;
    step(1);
    check("t6_launch", s_data_out, 0);
    break_req = 1'b1;
    check_frame("t6a", 16'h0055, 8, 16, 1'b0);
    step(30);
    check("t6_break_line", s_data_out, 0);
    check("t6_break_busy", busy, 1);
    check("t6_queued", fifo_level, 1);
    break_req = 1'b0;
    step(1);
    check("t6_mab_first", s_data_out, 1);
    check("t6_mab_busy", busy, 1);
    step(15);
    check("t6_mab_last", s_data_out, 1);
    step(1);
    check("t6_next_start", s_data_out, 0);
    check("t6_level0", fifo_level, 0);
    step(24);
    check("t6_mid_bit0", s_data_out, 0);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_line", s_data_out, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", u_if.ready, 0);
    step(1);
    reset = 1'b1;
    step(20);
    check("t6_after_rst_line", s_data_out, 1);
    check("t6_after_rst_busy", busy, 0);
    check("t6_after_rst_level", fifo_level, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_gen2.md
Name: uart_tx_gen2

Overview:
Second-generation UART transmitter with an integrated buffer FIFO, a direct (unbuffered) mode, and a frame engine. Character length is runtime-selectable, with odd, even or mark parity and 1, 1.5 or 2 stop bits. It adds break generation, FIFO flush, fill-level reporting and a sticky overflow flag. It sits between the host-side valid/ready byte interface and the serial TX pin, clocked by the system clock and paced by the shared oversampling tick bclk.

Parameters:
DATA_WIDTH, 8, maximum data bits per character (5..9); width of p_data_in.
SAMPLING, 16, bclk ticks per bit period (even, >=4).
FIFO_DEPTH, 16, TX FIFO entries (power of two, >=2); LVL_W = log2(FIFO_DEPTH)+1.

Ports:
clk  in  1  system clock, all flops on rising edge.
reset  in  1  asynchronous, active-low reset.
bclk  in  1  one-clk-wide oversample tick enable.
mode  in  1  0 = FIFO mode, 1 = direct mode.
char_len  in  4  data bits per character; values <5 are treated as 5, values >DATA_WIDTH as DATA_WIDTH.
parity_select  in  2  00 none, 01 odd, 10 even, 11 mark (constant 1).
stop_select  in  2  00 one, 01 two, 10 one-and-half, 11 two.
break_req  in  1  hold line low (break) while high.
flush  in  1  one-cycle pulse; empties FIFO.
valid  in  1  host data valid.
ready  out  1  block can accept p_data_in this cycle.
p_data_in  in  DATA_WIDTH  character; LSB sent first; bits above char_len ignored.
s_data_out  out  1  serial line, idle high.
busy  out  1  frame or break in progress.
fifo_level  out  LVL_W  current FIFO occupancy.
overflow  out  1  sticky: valid seen while ready=0 in FIFO mode; cleared by flush or reset.

Behaviour:
- Reset (async, reset=0): s_data_out=1, busy=0, ready=0 while in reset, fifo_level=0, overflow=0, FSM=IDLE, pointers cleared.
- Transfer occurs on a clk edge with valid&&ready.
- FIFO mode: ready = ~full. A transfer writes the FIFO; fifo_level increments the next cycle.
- Direct mode: ready = FSM in IDLE && no pending char && FIFO empty. A transfer latches the char into a one-entry pending register.
- Switching mode does not discard data: the FIFO keeps draining, and direct-mode ready stays 0 until it is empty.
- Simultaneous write and read on the same edge leaves fifo_level unchanged. Write when full is dropped and sets overflow. Pointers wrap modulo FIFO_DEPTH.
- flush: FIFO is empty the next cycle and overflow is cleared. A frame already loaded completes. A write in the same cycle as flush is dropped.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE -> START on a bclk pulse when a char is available (FIFO non-empty in FIFO mode, pending valid in direct mode) and break_req=0. On that same edge the char is popped/consumed, char_len/parity/stop are latched for the whole frame, s_data_out=0 and busy=1.
- Each bit lasts exactly SAMPLING bclk pulses; the tick counter advances only on bclk.
- START -> DATA. DATA shifts latched char_len bits, LSB first.
- DATA -> PARITY if parity != 00, else -> STOP. Parity bit: odd gives XOR of data bits inverted, even gives XOR of data bits, mark gives 1. XOR covers only the char_len bits.
- STOP drives 1 for SAMPLING, 2*SAMPLING or 3*SAMPLING/2 ticks per the latched stop_select.
- STOP -> START directly on its final tick if another char is available and break_req=0 (back-to-back frames, no idle gap). Otherwise -> BREAK if break_req=1, else -> IDLE with busy=0.
- IDLE -> BREAK on bclk when break_req=1. A pending char waits.
- BREAK: s_data_out=0, busy=1. On the first bclk with break_req=0, go to STOP and send one full stop period (mark-after-break), then proceed as a normal STOP exit.
- break_req asserted mid-frame is not honoured until the frame's stop bits finish.
- Config changes mid-frame have no effect until the next START.
- Reset mid-frame: line returns to 1 immediately and all buffered data is lost.

Test Plan:
- bclk=1 every cycle, mode=0, 8N1, send 0xA5 -> line low 16 clks, then 1,0,1,0,0,1,0,1 at 16 clks each, then high 16 clks; busy high 160 clks.
- char_len=7, even parity, two stop bits, send 0x53 -> 7 data bits 1,1,0,0,1,0,1; parity 0; 32 high ticks; bit 7 ignored.
- FIFO mode, push 17 words with line stalled (bclk=0) -> ready=0 after 16, fifo_level=16, 17th dropped, overflow=1; flush -> fifo_level=0, overflow=0.
- Push 3 words, bclk running -> three frames back-to-back with no idle between stop and next start; fifo_level 3->0.
- Direct mode, send 0x3C -> ready drops the next cycle and stays 0 until STOP ends; a second valid is not accepted while busy.
- break_req during frame 1 -> frame completes, line low while break_req high, then 16 high ticks before the queued frame starts; reset mid-frame -> s_data_out=1 asynchronously.
